// File: rtl/hex_display_pkg.sv
// Shared constants, types and helpers for the multi-digit seven-segment display.
package hex_display_pkg;

  // Register map
  localparam logic [2:0] ADDR_VALUE  = 3'd0;
  localparam logic [2:0] ADDR_MODE   = 3'd1;
  localparam logic [2:0] ADDR_BLANK  = 3'd2;
  localparam logic [2:0] ADDR_BLINK  = 3'd3;
  localparam logic [2:0] ADDR_RAW0   = 3'd4;
  localparam logic [2:0] ADDR_RAW1   = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  // MODE[1:0] encodings; any value with bit 1 set selects raw segments
  localparam logic [1:0] MODE_HEX = 2'd0;
  localparam logic [1:0] MODE_DEC = 2'd1;

  // Double-dabble conversion states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  // Active-high segment patterns, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_A    = 7'h77;
  localparam logic [6:0] SEG_B    = 7'h7C;
  localparam logic [6:0] SEG_C    = 7'h39;
  localparam logic [6:0] SEG_D    = 7'h5E;
  localparam logic [6:0] SEG_E    = 7'h79;
  localparam logic [6:0] SEG_F    = 7'h71;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Number of BCD nibbles needed to hold any data_w-bit binary value, plus one spare
  function automatic int bcd_digits(input int data_w);
    return (3 * data_w + 9) / 10 + 1;
  endfunction

  // Hex nibble to segment pattern; b and d are lowercase so they differ from 8 and 0
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one bit per cycle, DATA_W+1 cycles busy.
module bin2bcd_seq
  import hex_display_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int BCD_DIGITS = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       value,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int BCD_W = 4 * BCD_DIGITS;

  conv_state_e       state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Add-3 correction: any nibble >= 5 would overflow past 9 on the next shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state logic: load on start, shift DATA_W times, then hold the result for one DONE cycle
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          sh_d    = value;
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        bcd_d = {adj[BCD_W-2:0], sh_q[DATA_W-1]};
        sh_d  = {sh_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/hex_display_multi.sv
// Avalon-MM seven-segment display controller: hex, decimal or raw digits with blank/blink/LZS.
module hex_display_multi
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 24,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              avs_address,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic                    avs_read,
  output logic [31:0]             avs_readdata,
  output logic                    avs_waitrequest,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy
);

  localparam int BCD_DIGITS = bcd_digits(DATA_W);
  localparam int EXT_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int CNT_W      = $clog2(BLINK_DIV);
  localparam int SEG_W      = 7 * NUM_DIGITS;
  localparam logic [SEG_W-1:0] HEX_ALL_OFF = (ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

  logic [DATA_W-1:0]       value_q, value_d;
  logic [1:0]              mode_q, mode_d;
  logic                    lzs_q, lzs_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   blink_q, blink_d;
  logic [27:0]             raw0_q, raw0_d;
  logic [27:0]             raw1_q, raw1_d;
  logic [4*NUM_DIGITS-1:0] dec_q, dec_d;
  logic                    ovf_q, ovf_d;
  logic [CNT_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    blink_ph_q, blink_ph_d;
  logic [31:0]             readdata_q, readdata_d;
  logic [SEG_W-1:0]        hex_q, hex_d;

  logic                    wr_ok;
  logic                    conv_start;
  logic                    conv_busy;
  logic                    conv_done;
  logic [4*BCD_DIGITS-1:0] conv_bcd;
  logic [4*EXT_DIGITS-1:0] bcd_ext;
  logic [31:0]             rd_mux;
  logic [31:0]             value_ext;
  logic [55:0]             raw_all;
  logic [SEG_W-1:0]        seg_all;
  logic [3:0]              nib;
  logic [6:0]              pat;
  logic                    nz_above;

  // VALUE and MODE writes must not change the operands of a running conversion
  assign avs_waitrequest = avs_write & conv_busy &
                           ((avs_address == ADDR_VALUE) | (avs_address == ADDR_MODE));
  assign wr_ok = avs_write & ~avs_waitrequest;

  // Register writes; a write that leaves the block in decimal mode launches a conversion
  always_comb begin
    value_d    = value_q;
    mode_d     = mode_q;
    lzs_d      = lzs_q;
    blank_d    = blank_q;
    blink_d    = blink_q;
    raw0_d     = raw0_q;
    raw1_d     = raw1_q;
    conv_start = 1'b0;
    if (wr_ok) begin
      case (avs_address)
        ADDR_VALUE: begin
          value_d    = avs_writedata[DATA_W-1:0];
          conv_start = (mode_q == MODE_DEC);
        end
        ADDR_MODE: begin
          mode_d     = avs_writedata[1:0];
          lzs_d      = avs_writedata[2];
          conv_start = (avs_writedata[1:0] == MODE_DEC);
        end
        ADDR_BLANK: blank_d = avs_writedata[NUM_DIGITS-1:0];
        ADDR_BLINK: blink_d = avs_writedata[NUM_DIGITS-1:0];
        ADDR_RAW0:  raw0_d  = avs_writedata[27:0];
        ADDR_RAW1:  raw1_d  = avs_writedata[27:0];
        default: ;
      endcase
    end
  end

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .value (value_d),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign busy = conv_busy;

  // Latch the finished conversion atomically so the display never shows partial digits
  always_comb begin
    bcd_ext                   = '0;
    bcd_ext[4*BCD_DIGITS-1:0] = conv_bcd;
    dec_d                     = dec_q;
    ovf_d                     = ovf_q;
    if (conv_done) begin
      dec_d = bcd_ext[4*NUM_DIGITS-1:0];
      ovf_d = 1'b0;
      for (int i = NUM_DIGITS; i < EXT_DIGITS; i++) begin
        if (bcd_ext[4*i +: 4] != 4'd0) begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  // Free-running blink divider; the phase flips each time the counter wraps
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_ph_d  = blink_ph_q;
    if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  // Read mux; readdata only updates on a read strobe and holds otherwise
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_VALUE:  rd_mux[DATA_W-1:0]     = value_q;
      ADDR_MODE:   rd_mux[2:0]            = {lzs_q, mode_q};
      ADDR_BLANK:  rd_mux[NUM_DIGITS-1:0] = blank_q;
      ADDR_BLINK:  rd_mux[NUM_DIGITS-1:0] = blink_q;
      ADDR_RAW0:   rd_mux[27:0]           = raw0_q;
      ADDR_RAW1:   rd_mux[27:0]           = raw1_q;
      ADDR_STATUS: rd_mux[1:0]            = {ovf_q, conv_busy};
      default: ;
    endcase
    readdata_d = avs_read ? rd_mux : readdata_q;
  end

  // Per-digit decode, scanning from the top digit so LZS knows if anything nonzero lies above
  always_comb begin
    value_ext               = '0;
    value_ext[DATA_W-1:0]   = value_q;
    raw_all                 = {raw1_q, raw0_q};
    seg_all                 = '0;
    nz_above                = 1'b0;
    nib                     = '0;
    pat                     = SEG_OFF;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib = (mode_q == MODE_DEC) ? dec_q[4*k +: 4] : value_ext[4*k +: 4];
      if (nib != 4'd0) begin
        nz_above = 1'b1;
      end
      if (mode_q[1]) begin
        pat = raw_all[7*k +: 7];
      end else if ((mode_q == MODE_DEC) && ovf_q) begin
        pat = SEG_DASH;
      end else if (lzs_q && !nz_above && (k != 0)) begin
        pat = SEG_OFF;
      end else begin
        pat = hex_seg(nib);
      end
      if (blank_q[k] || (blink_q[k] && blink_ph_q)) begin
        pat = SEG_OFF;
      end
      seg_all[7*k +: 7] = pat;
    end
    hex_d = (ACTIVE_LOW != 0) ? ~seg_all : seg_all;
  end

  // All state registers; polarity is applied only at the hex_out register
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q     <= '0;
      mode_q      <= MODE_HEX;
      lzs_q       <= 1'b0;
      blank_q     <= '0;
      blink_q     <= '0;
      raw0_q      <= '0;
      raw1_q      <= '0;
      dec_q       <= '0;
      ovf_q       <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      readdata_q  <= '0;
      hex_q       <= HEX_ALL_OFF;
    end else begin
      value_q     <= value_d;
      mode_q      <= mode_d;
      lzs_q       <= lzs_d;
      blank_q     <= blank_d;
      blink_q     <= blink_d;
      raw0_q      <= raw0_d;
      raw1_q      <= raw1_d;
      dec_q       <= dec_d;
      ovf_q       <= ovf_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      readdata_q  <= readdata_d;
      hex_q       <= hex_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign hex_out      = hex_q;

endmodule

// File: doc/hex_display_multi.md
Name: hex_display_multi

Overview:
Parametrised successor to the fixed six-digit hex display peripheral, built as an Avalon-MM slave on the Nios system bus.
Drives NUM_DIGITS seven-segment digits from a binary value in one of three modes: hexadecimal, decimal, or raw segments.
- Decimal mode uses a sequential double-dabble converter.
- Per-digit blanking and blinking are supported, as is leading-zero suppression.
- Sits beside the LED and VGA components; its hex_out bus is exported to the board pins.

Parameters:
NUM_DIGITS, 6, number of digits driven; legal range 1..8.
DATA_W, 24, width of the VALUE register in bits; legal range 4..32.
BLINK_DIV, 25000000, clock cycles per blink half-period; minimum 2.
ACTIVE_LOW, 1, 1 = segment lit when its bit is 0 (DE1-SoC); 0 = lit when 1.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
avs_address  in  3  register index.
avs_write  in  1  write strobe.
avs_writedata  in  32  write data.
avs_read  in  1  read strobe.
avs_readdata  out  32  read data, readLatency 1.
avs_waitrequest  out  1  stalls VALUE/MODE writes while a conversion is running.
hex_out  out  7*NUM_DIGITS  segments; digit k occupies [7k+6:7k]; bit 0 = a ... bit 6 = g.
busy  out  1  high while a decimal conversion is in progress.

Behaviour:
Register map (unused bits read as 0):
- 0 VALUE[DATA_W-1:0]
- 1 MODE: [1:0] 0 = hex, 1 = dec, 2 = raw, 3 = raw; [2] LZS (leading-zero suppress)
- 2 BLANK[NUM_DIGITS-1:0]
- 3 BLINK[NUM_DIGITS-1:0]
- 4 RAW0: 7-bit patterns for digits 0..3 at [7k+6:7k]
- 5 RAW1: digits 4..7
- 6 STATUS: [0] busy, [1] ovf
- 7 reserved: writes ignored, reads return 0

Reset:
- All registers, the blink counter and blink phase clear to 0; FSM goes to IDLE.
- avs_readdata = 0, busy = 0, avs_waitrequest = 0.
- hex_out = all segments off: all ones when ACTIVE_LOW = 1.
- The cycle after reset deasserts, hex_out shows "0" on every digit (hex mode, VALUE = 0).

Bus:
- Reads: avs_readdata is registered, valid the cycle after avs_read; it holds its value otherwise.
- Writes: accepted on the edge where avs_write = 1 and avs_waitrequest = 0.
- avs_waitrequest = avs_write & busy & (address == 0 or address == 1). It is combinational; writes to other addresses never stall.

Conversion FSM (IDLE, SHIFT, DONE):
- IDLE -> SHIFT on any accepted write to VALUE or MODE while the resulting mode = dec. Also starts one conversion after reset deasserts if MODE = dec (it never is at reset, so no start occurs).
- SHIFT: DATA_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift the value's MSB in.
- BCD_DIGITS = (3*DATA_W+9)/10 + 1.
- DONE: one cycle. Latch the low NUM_DIGITS nibbles into the display latch; ovf = any higher nibble nonzero. Return to IDLE.
- busy = 1 in SHIFT and DONE. Total latency from the accepting edge to display update is DATA_W+1 cycles.
- While busy, the display keeps the previous decimal result. No glitch, no partial digits.
- Reset mid-conversion aborts to IDLE and clears the latch and ovf.
- Leaving dec mode mid-conversion is impossible: the MODE write stalls until the conversion finishes.

Digit decode (combinational from registers, then registered into hex_out; 1-cycle latency from register change):
- hex: nibble k of VALUE, decoded 0-F, where b and d are lowercase.
- dec: latched BCD nibble. If ovf = 1, every digit shows "-" (segment g only).
- raw: RAW pattern for digit k.
- LZS (hex/dec only): zero digits above the most significant nonzero digit are blanked. Digit 0 is always shown. LZS is ignored when ovf = 1.
- Blanking precedence, highest first: BLANK[k] -> blink off-phase with BLINK[k] -> mode pattern.

Blink timing:
- The counter counts 0..BLINK_DIV-1 and then wraps. The phase toggles on the wrap.
- Phase 0 = on after reset.
- The counter runs freely; it is not affected by bus writes.

Polarity: ACTIVE_LOW inversion is applied at the hex_out register only; patterns are stored active-high.

Decomposition:
Package hex_display_pkg:
- Register address constants and mode encodings.
- Conversion FSM state typedef.
- Seven-segment pattern constants: 0-F, dash, off.
- Function bcd_digits(DATA_W).

Sub-module bin2bcd_seq holds the double-dabble engine, parametrised by DATA_W and BCD_DIGITS.
- Inputs: start, value.
- Outputs: busy, done pulse, bcd.

Test Plan:
- Reset hold 3 cycles, ACTIVE_LOW = 1 -> hex_out = all ones during reset; next cycle every digit = 7'b1000000 ("0").
- Write VALUE = 0x00BEEF in hex mode with LZS = 1 -> after 1 cycle digits 5..0 = off, off, b, E, E, F.
- MODE = dec; write VALUE = 123456 -> busy high for exactly 25 cycles; display shows 123456 only after busy falls.
- While busy, write VALUE again -> avs_waitrequest = 1 until busy falls; then accepted; a write to BLANK in the same window is not stalled.
- Dec mode, VALUE = 1000000 (NUM_DIGITS = 6) -> STATUS.ovf = 1 and all digits show 7'b0111111 (dash, active-low).
- BLINK_DIV = 4, BLINK = 0x01, raw mode RAW0 digit 0 = 7'h7F -> digit 0 alternates lit/off every 4 cycles; BLANK[0] = 1 forces it off in both phases.
